tetris_line_clear: RTL and testbench

- Row-elimination engine that runs once a falling piece has locked.
- Started by tetris_control. Scans the 21x41 board in shared SRAM from the bottom row to the top and finds full rows (no white cell).
- For each full row, shifts every row above it down by one and fills row 0 with white.
- Owns the SRAM port while busy; tetris_control muxes this block's address, data and strobes onto SRAM while busy=1.

---
 rtl/tetris_line_clear.sv | 203 ++++++++++++++++++++
 tb/tb_tetris_line_clear.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/tetris_line_clear.sv
// Row-elimination engine: scans the board bottom-up for full rows, shifts
// everything above a full row down by one, and whitens the top row.
// Holds the SRAM port while busy; all outputs except the shift write data
// are registered.
module tetris_line_clear #(
  parameter int COLS = 21,
  parameter int ROWS = 41,
  parameter int XW   = 5,
  parameter int YW   = 6,
  parameter int CW   = 4,
  parameter logic [CW-1:0] WHITE = 4'd7
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic [2:0]    rows_cleared,
  output logic          sram_re,
  output logic          sram_we,
  output logic [XW-1:0] addr_x,
  output logic [YW-1:0] addr_y,
  output logic [CW-1:0] sram_wdata,
  input  logic [CW-1:0] sram_rdata
);

  localparam logic [XW-1:0] X_LAST = XW'(COLS - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(ROWS - 1);
  localparam logic [XW-1:0] X_ONE  = XW'(1);
  localparam logic [YW-1:0] Y_ONE  = YW'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_SCAN_RD, S_SCAN_CHK, S_SHIFT_RD, S_SHIFT_WR, S_CLEAR_TOP, S_DONE
  } state_t;

  state_t        state_r, state_s;
  logic [XW-1:0] x_r, x_s;
  logic [YW-1:0] y_r, y_s;
  logic [YW-1:0] r_r, r_s;
  logic [2:0]    cnt_r, cnt_s;

  logic          busy_s, done_s, re_s, we_s;
  logic [XW-1:0] ax_s;
  logic [YW-1:0] ay_s;
  logic [CW-1:0] wd_r, wd_s;
  logic [2:0]    rc_s;

  // Next-state and scan/shift counter update.
  always_comb begin
    state_s = state_r;
    x_s     = x_r;
    y_s     = y_r;
    r_s     = r_r;
    cnt_s   = cnt_r;
    case (state_r)
      S_IDLE: begin
        if (start) begin
          state_s = S_SCAN_RD;
          y_s     = Y_LAST;
          x_s     = '0;
          cnt_s   = 3'd0;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_SCAN_RD: state_s = S_SCAN_CHK;
      S_SCAN_CHK: begin
        if (sram_rdata == WHITE) begin
          // Early exit: a white cell means this row cannot be full.
          if (y_r == '0) begin
            state_s = S_DONE;
          end else begin
            y_s     = y_r - Y_ONE;
            x_s     = '0;
            state_s = S_SCAN_RD;
          end
        end else if (x_r != X_LAST) begin
          x_s     = x_r + X_ONE;
          state_s = S_SCAN_RD;
        end else begin
          x_s = '0;
          r_s = y_r;
          if (y_r == '0) begin
            state_s = S_CLEAR_TOP;
          end else begin
            state_s = S_SHIFT_RD;
          end
        end
      end
      S_SHIFT_RD: state_s = S_SHIFT_WR;
      S_SHIFT_WR: begin
        if (x_r != X_LAST) begin
          x_s     = x_r + X_ONE;
          state_s = S_SHIFT_RD;
        end else if (r_r > Y_ONE) begin
          r_s     = r_r - Y_ONE;
          x_s     = '0;
          state_s = S_SHIFT_RD;
        end else begin
          x_s     = '0;
          state_s = S_CLEAR_TOP;
        end
      end
      S_CLEAR_TOP: begin
        if (x_r != X_LAST) begin
          x_s = x_r + X_ONE;
        end else begin
          // Rescan the same y: the row that just dropped in may be full too.
          cnt_s   = (cnt_r == 3'd7) ? cnt_r : cnt_r + 3'd1;
          x_s     = '0;
          state_s = S_SCAN_RD;
        end
      end
      S_DONE:  state_s = S_IDLE;
      default: state_s = S_IDLE;
    endcase
  end

  // Output values decoded from the state being entered, so they register
  // in step with the state.
  always_comb begin
    busy_s = 1'b1;
    done_s = 1'b0;
    re_s   = 1'b0;
    we_s   = 1'b0;
    ax_s   = addr_x;
    ay_s   = addr_y;
    wd_s   = wd_r;
    rc_s   = rows_cleared;
    case (state_s)
      S_IDLE: begin
        busy_s = 1'b0;
        ax_s   = '0;
        ay_s   = '0;
        wd_s   = '0;
      end
      S_SCAN_RD: begin
        re_s = 1'b1;
        ax_s = x_s;
        ay_s = y_s;
      end
      S_SCAN_CHK: busy_s = 1'b1;
      S_SHIFT_RD: begin
        re_s = 1'b1;
        ax_s = x_s;
        ay_s = r_s - Y_ONE;
      end
      S_SHIFT_WR: begin
        we_s = 1'b1;
        ax_s = x_s;
        ay_s = r_s;
      end
      S_CLEAR_TOP: begin
        we_s = 1'b1;
        ax_s = x_s;
        ay_s = '0;
        wd_s = WHITE;
      end
      S_DONE: begin
        done_s = 1'b1;
        rc_s   = cnt_s;
      end
      default: busy_s = 1'b0;
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r      <= S_IDLE;
      x_r          <= '0;
      y_r          <= '0;
      r_r          <= '0;
      cnt_r        <= 3'd0;
      busy         <= 1'b0;
      done         <= 1'b0;
      sram_re      <= 1'b0;
      sram_we      <= 1'b0;
      addr_x       <= '0;
      addr_y       <= '0;
      wd_r         <= '0;
      rows_cleared <= 3'd0;
    end else begin
      state_r      <= state_s;
      x_r          <= x_s;
      y_r          <= y_s;
      r_r          <= r_s;
      cnt_r        <= cnt_s;
      busy         <= busy_s;
      done         <= done_s;
      sram_re      <= re_s;
      sram_we      <= we_s;
      addr_x       <= ax_s;
      addr_y       <= ay_s;
      wd_r         <= wd_s;
      rows_cleared <= rc_s;
    end
  end

  // A shift write forwards the cell read one cycle earlier straight through.
  assign sram_wdata = (state_r == S_SHIFT_WR) ? sram_rdata : wd_r;

endmodule

// File: tb/tb_tetris_line_clear.sv
// Directed bench for tetris_line_clear with a behavioural board SRAM and a
// protocol monitor on the strobes.
module tb_tetris_line_clear;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       busy, done, sram_re, sram_we;
  logic [2:0] rows_cleared;
  logic [4:0] addr_x;
  logic [5:0] addr_y;
  logic [3:0] sram_wdata;
  logic [3:0] sram_rdata;

  int n_cmp = 0;
  int n_bad = 0;

  tetris_line_clear dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .rows_cleared(rows_cleared), .sram_re(sram_re), .sram_we(sram_we),
    .addr_x(addr_x), .addr_y(addr_y), .sram_wdata(sram_wdata),
    .sram_rdata(sram_rdata)
  );

  always #5 clk = ~clk;

  // Board SRAM model with a bench load port
  logic [3:0] mem [0:40][0:20];
  logic       fill_white = 1'b0;
  logic       ld = 1'b0;
  logic [5:0] ld_y = 6'd0;
  logic [4:0] ld_x = 5'd0;
  logic [3:0] ld_v = 4'd0;

  always @(posedge clk) begin
    if (fill_white) begin
      for (int i = 0; i < 41; i++)
        for (int j = 0; j < 21; j++)
          mem[i][j] <= 4'd7;
    end else if (ld) begin
      mem[ld_y][ld_x] <= ld_v;
    end else if (sram_we && addr_y < 6'd41 && addr_x < 5'd21) begin
      mem[addr_y][addr_x] <= sram_wdata;
    end
    if (sram_re && addr_y < 6'd41 && addr_x < 5'd21)
      sram_rdata <= mem[addr_y][addr_x];
  end

  // Protocol monitor
  int         m_both = 0, m_reads = 0, m_reads_xnz = 0, m_writes = 0;
  int         m_shift = 0, m_shift_bad = 0;
  logic       p_re = 1'b0;
  logic [4:0] p_ax = 5'd0;
  logic [5:0] p_ay = 6'd0;
  logic [3:0] p_val = 4'd0;

  always @(negedge clk) begin
    if (sram_re && sram_we) m_both <= m_both + 1;
    if (sram_re) m_reads <= m_reads + 1;
    if (sram_re && addr_x != 5'd0) m_reads_xnz <= m_reads_xnz + 1;
    if (sram_we) m_writes <= m_writes + 1;
    if (sram_we && p_re) begin
      m_shift <= m_shift + 1;
      if (sram_wdata != p_val || addr_x != p_ax || addr_y != p_ay + 6'd1)
        m_shift_bad <= m_shift_bad + 1;
    end
    p_re <= sram_re;
    p_ax <= addr_x;
    p_ay <= addr_y;
    if (addr_y < 6'd41 && addr_x < 5'd21) p_val <= mem[addr_y][addr_x];
    else p_val <= 4'd0;
  end

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear_board();
    @(negedge clk); fill_white = 1'b1;
    @(negedge clk); fill_white = 1'b0;
  endtask

  task automatic set_cell(input int y, input int x, input int v);
    @(negedge clk);
    ld = 1'b1; ld_y = 6'(y); ld_x = 5'(x); ld_v = 4'(v);
    @(negedge clk); ld = 1'b0;
  endtask

  task automatic fill_row(input int y, input int v);
    for (int x = 0; x < 21; x++) set_cell(y, x, v);
  endtask

  function automatic int count_nonwhite();
    int n = 0;
    for (int i = 0; i < 41; i++)
      for (int j = 0; j < 21; j++)
        if (mem[i][j] != 4'd7) n++;
    return n;
  endfunction

  // Pulse start and wait for done; cyc = cycle index of done after the start edge.
  task automatic run_pass(output int cyc);
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    cyc = 1;
    while (!done && cyc < 20000) begin
      @(posedge clk); #1; cyc++;
    end
    check("done_seen", int'(done), 1);
    @(posedge clk); #1;
  endtask

  int cyc, r0, w0, s0, dn;

  initial begin
    // Reset state
    #12;
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_strobes", int'({sram_re, sram_we}), 0);
    check("rst_addr", int'({addr_x, addr_y}), 0);
    check("rst_rows", int'(rows_cleared), 0);
    @(negedge clk); reset = 1'b1;

    // Empty board
    clear_board();
    r0 = m_reads; w0 = m_writes;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    check("empty_busy_c1", int'(busy), 1);
    cyc = 1;
    while (!done && cyc < 20000) begin
      @(posedge clk); #1; cyc++;
    end
    check("empty_done_cycle", cyc, 83);
    check("empty_rows", int'(rows_cleared), 0);
    @(posedge clk); #1;
    check("empty_idle_busy", int'(busy), 0);
    check("empty_reads", m_reads - r0, 41);
    check("empty_reads_x0", m_reads_xnz, 0);
    check("empty_writes", m_writes - w0, 0);

    // Row 40 full, one cell above
    clear_board();
    fill_row(40, 3);
    set_cell(39, 5, 2);
    s0 = m_shift;
    run_pass(cyc);
    check("r40_rows", int'(rows_cleared), 1);
    check("r40_cell5", int'(mem[40][5]), 2);
    check("r40_cell4", int'(mem[40][4]), 7);
    check("r40_cell39_5", int'(mem[39][5]), 7);
    check("r40_nonwhite", count_nonwhite(), 1);
    check("r40_shift_cnt", m_shift - s0, 840);

    // Rows 40 and 38 full, single cell in row 39
    clear_board();
    fill_row(40, 3);
    fill_row(38, 3);
    set_cell(39, 0, 1);
    run_pass(cyc);
    check("two_rows", int'(rows_cleared), 2);
    check("two_cell0", int'(mem[40][0]), 1);
    check("two_nonwhite", count_nonwhite(), 1);

    // Only row 0 full
    clear_board();
    fill_row(0, 5);
    s0 = m_shift; w0 = m_writes;
    run_pass(cyc);
    check("top_rows", int'(rows_cleared), 1);
    check("top_shift", m_shift - s0, 0);
    check("top_writes", m_writes - w0, 21);
    check("top_nonwhite", count_nonwhite(), 0);

    // Start re-pulsed while busy
    clear_board();
    fill_row(40, 3);
    set_cell(39, 5, 2);
    dn = 0;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    for (int c = 1; c < 4000; c++) begin
      if (done) dn++;
      start = (c == 5 || c == 100 || c == 700) ? 1'b1 : 1'b0;
      @(posedge clk); #1;
    end
    start = 1'b0;
    check("repulse_dones", dn, 1);
    check("repulse_rows", int'(rows_cleared), 1);
    check("repulse_nonwhite", count_nonwhite(), 1);

    // Reset during a shift write
    clear_board();
    fill_row(40, 3);
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    cyc = 0;
    while (!sram_we && cyc < 200) begin
      @(negedge clk); cyc++;
    end
    check("midrst_in_write", int'(sram_we), 1);
    reset = 1'b0;
    #1;
    check("midrst_busy", int'(busy), 0);
    check("midrst_we", int'(sram_we), 0);
    @(posedge clk); #1;
    check("midrst_busy_next", int'(busy), 0);
    check("midrst_strobes_next", int'({sram_re, sram_we}), 0);
    @(negedge clk); reset = 1'b1;
    clear_board();
    fill_row(40, 3);
    set_cell(39, 5, 2);
    run_pass(cyc);
    check("after_rst_rows", int'(rows_cleared), 1);
    check("after_rst_cell5", int'(mem[40][5]), 2);
    check("after_rst_nonwhite", count_nonwhite(), 1);

    // Protocol totals across every test
    check("mon_re_we_both", m_both, 0);
    check("mon_shift_data", m_shift_bad, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
